// File: rtl/epass_reader_if.sv
// Signal bundle between the E-pass reader and its surroundings:
// the serial line from the RFID transceiver, the acknowledge from the
// ETC controller, and the published verdict.
interface epass_reader_if;
    logic        rx;
    logic        clear;
    logic [1:0]  valid_Epass;
    logic [31:0] tag_id;
    logic        result_stb;

    // Reader side: consumes the line and the acknowledge, drives the verdict.
    modport slave (
        input  rx,
        input  clear,
        output valid_Epass,
        output tag_id,
        output result_stb
    );

    // Environment side: drives the line and the acknowledge, observes the verdict.
    modport master (
        output rx,
        output clear,
        input  valid_Epass,
        input  tag_id,
        input  result_stb
    );
endinterface

// File: rtl/epass_reader.sv
// E-pass tag reader: 8N1 UART receiver, 8-byte frame parser with XOR
// checksum, toll comparison and a held, acknowledgeable verdict.
module epass_reader #(
    parameter int SYS_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int TOLL         = 20,
    parameter int TIMEOUT_BITS = 20,
    parameter int HOLD_CYCLES  = 100000000
) (
    input  logic          clk,
    input  logic          reset,
    epass_reader_if.slave bus
);
    localparam int CLKS_PER_BIT = SYS_FREQ / BAUD;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W         = $clog2(TO_CYCLES + 1);
    localparam int HOLD_W       = $clog2(HOLD_CYCLES + 1);

    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TO_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]        TOLL_B    = 8'(TOLL);

    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;

    localparam logic [1:0] V_NONE = 2'b00;
    localparam logic [1:0] V_PAID = 2'b01;
    localparam logic [1:0] V_LOW  = 2'b10;
    localparam logic [1:0] V_ERR  = 2'b11;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [2:0] {P_HUNT, P_ID, P_BAL, P_CHK, P_ETX} parse_state_t;

    // Paid/low-balance decision for a frame whose checksum and ETX are good.
    function automatic logic [1:0] balance_verdict(input logic [7:0] bal);
        if (bal >= TOLL_B) begin
            balance_verdict = V_PAID;
        end else begin
            balance_verdict = V_LOW;
        end
    endfunction

    // ---------------- UART receiver ----------------
    logic              r_rx_meta;
    logic              r_rx_sync;
    logic              r_rx_prev;
    uart_state_t       r_u_state;
    uart_state_t       w_u_next;
    logic              w_sample;
    logic              w_fall;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_byte_valid;
    logic              r_ferr;

    assign w_fall = r_rx_prev & ~r_rx_sync;

    // Two-flop synchroniser for the asynchronous line plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // UART state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_u_state <= U_IDLE;
        end else begin
            r_u_state <= w_u_next;
        end
    end

    // UART next state and the per-bit sampling strobe.
    always_comb begin
        w_u_next = r_u_state;
        w_sample = 1'b0;
        case (r_u_state)
            U_IDLE: begin
                if (w_fall) begin
                    w_u_next = U_START;
                end else begin
                    w_u_next = U_IDLE;
                end
            end
            U_START: begin
                if (r_baud_cnt == BAUD_HALF) begin
                    w_sample = 1'b1;
                    // A start bit that is high again at its midpoint was a glitch.
                    if (r_rx_sync) begin
                        w_u_next = U_IDLE;
                    end else begin
                        w_u_next = U_DATA;
                    end
                end else begin
                    w_u_next = U_START;
                end
            end
            U_DATA: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    w_sample = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_u_next = U_STOP;
                    end else begin
                        w_u_next = U_DATA;
                    end
                end else begin
                    w_u_next = U_DATA;
                end
            end
            U_STOP: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    w_sample = 1'b1;
                    w_u_next = U_IDLE;
                end else begin
                    w_u_next = U_STOP;
                end
            end
            default: begin
                w_u_next = U_IDLE;
            end
        endcase
    end

    // Baud timing, bit shifting and byte/framing-error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud_cnt   <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_ferr       <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_ferr       <= 1'b0;
            if ((r_u_state == U_IDLE) || w_sample) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
            end
            if (r_u_state == U_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_u_state == U_DATA) && w_sample) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
                if (r_bit_idx != 3'd7) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end else begin
                    r_bit_idx <= r_bit_idx;
                end
            end else if ((r_u_state == U_STOP) && w_sample) begin
                r_byte_valid <= r_rx_sync;
                r_ferr       <= ~r_rx_sync;
            end else begin
                r_bit_idx <= r_bit_idx;
            end
        end
    end

    // ---------------- Frame parser ----------------
    parse_state_t    r_p_state;
    parse_state_t    w_p_next;
    logic [1:0]      r_idx;
    logic [1:0]      w_idx_next;
    logic [31:0]     r_id;
    logic [31:0]     w_id_next;
    logic [7:0]      r_bal;
    logic [7:0]      w_bal_next;
    logic [7:0]      r_acc;
    logic [7:0]      w_acc_next;
    logic            r_chk_ok;
    logic            w_chk_ok_next;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    logic            w_pub;
    logic [1:0]      w_pub_code;
    logic            w_tag_load;

    assign w_timeout = (r_p_state != P_HUNT) && (r_to_cnt == TO_LIMIT) && !r_byte_valid;

    // Parser state and frame field registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_state <= P_HUNT;
            r_idx     <= 2'd0;
            r_id      <= 32'h0000_0000;
            r_bal     <= 8'h00;
            r_acc     <= 8'h00;
            r_chk_ok  <= 1'b0;
        end else begin
            r_p_state <= w_p_next;
            r_idx     <= w_idx_next;
            r_id      <= w_id_next;
            r_bal     <= w_bal_next;
            r_acc     <= w_acc_next;
            r_chk_ok  <= w_chk_ok_next;
        end
    end

    // Inter-byte gap counter; idle in HUNT, restarted by every byte, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if ((r_p_state == P_HUNT) || r_byte_valid) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_LIMIT) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    // Parser next state, field capture and verdict decision.
    always_comb begin
        w_p_next      = r_p_state;
        w_idx_next    = r_idx;
        w_id_next     = r_id;
        w_bal_next    = r_bal;
        w_acc_next    = r_acc;
        w_chk_ok_next = r_chk_ok;
        w_pub         = 1'b0;
        w_pub_code    = V_NONE;
        w_tag_load    = 1'b0;
        if ((r_p_state != P_HUNT) && (r_ferr || w_timeout)) begin
            w_pub      = 1'b1;
            w_pub_code = V_ERR;
            w_p_next   = P_HUNT;
        end else if (r_byte_valid) begin
            case (r_p_state)
                P_HUNT: begin
                    if (r_shift == STX) begin
                        w_p_next   = P_ID;
                        w_idx_next = 2'd0;
                        w_acc_next = 8'h00;
                    end else begin
                        w_p_next = P_HUNT;
                    end
                end
                P_ID: begin
                    if (r_shift == STX) begin
                        w_p_next   = P_ID;
                        w_idx_next = 2'd0;
                        w_acc_next = 8'h00;
                    end else begin
                        w_id_next  = {r_id[23:0], r_shift};
                        w_acc_next = r_acc ^ r_shift;
                        if (r_idx == 2'd3) begin
                            w_p_next = P_BAL;
                        end else begin
                            w_idx_next = r_idx + 2'd1;
                        end
                    end
                end
                P_BAL: begin
                    if (r_shift == STX) begin
                        w_p_next   = P_ID;
                        w_idx_next = 2'd0;
                        w_acc_next = 8'h00;
                    end else begin
                        w_bal_next = r_shift;
                        w_acc_next = r_acc ^ r_shift;
                        w_p_next   = P_CHK;
                    end
                end
                P_CHK: begin
                    // Any value, 0x02 included, is a legitimate checksum here.
                    w_chk_ok_next = (r_shift == r_acc);
                    w_p_next      = P_ETX;
                end
                P_ETX: begin
                    if (r_shift == STX) begin
                        w_p_next   = P_ID;
                        w_idx_next = 2'd0;
                        w_acc_next = 8'h00;
                    end else begin
                        w_pub    = 1'b1;
                        w_p_next = P_HUNT;
                        if ((r_shift == ETX) && r_chk_ok) begin
                            w_tag_load = 1'b1;
                            w_pub_code = balance_verdict(r_bal);
                        end else begin
                            w_pub_code = V_ERR;
                        end
                    end
                end
                default: begin
                    w_p_next = P_HUNT;
                end
            endcase
        end else begin
            w_p_next = r_p_state;
        end
    end

    // ---------------- Verdict publication and hold ----------------
    logic [1:0]        r_valid;
    logic [31:0]       r_tag;
    logic              r_stb;
    logic [HOLD_W-1:0] r_hold_cnt;

    // Publish verdicts; a new verdict beats clear, otherwise clear or hold expiry drop it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= V_NONE;
            r_tag      <= 32'h0000_0000;
            r_stb      <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_stb <= w_pub;
            if (w_pub) begin
                r_valid    <= w_pub_code;
                r_hold_cnt <= '0;
                if (w_tag_load) begin
                    r_tag <= r_id;
                end else begin
                    r_tag <= r_tag;
                end
            end else if (r_valid != V_NONE) begin
                if (bus.clear || (r_hold_cnt == HOLD_LAST)) begin
                    r_valid    <= V_NONE;
                    r_hold_cnt <= '0;
                end else begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                end
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign bus.valid_Epass = r_valid;
    assign bus.tag_id      = r_tag;
    assign bus.result_stb  = r_stb;

endmodule

// File: tb/tb_epass_reader.sv
// Bench for epass_reader: table of frames plus hand-written sequences for
// hold timing, clear, timeout, resync, glitch, simultaneity and reset.
module tb_epass_reader;
    localparam int CPB  = 16;
    localparam int HOLD = 500;

    logic clk = 1'b0;
    logic reset;
    epass_reader_if bus();

    epass_reader #(
        .SYS_FREQ(1600), .BAUD(100), .TOLL(20), .TIMEOUT_BITS(20), .HOLD_CYCLES(500)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0] id;
        logic [7:0]  bal;
        logic        chk_bad;
        logic [7:0]  etx;
        int          bad_idx;
        logic [1:0]  exp_v;
        logic [31:0] exp_tag;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   last_stb_cyc = 0;
    int   t_last = 0;
    int   lat = 0;
    int   step = 0;
    vec_t vecs[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s (step %0d): got %h, expected %h", name, step, act, exp);
    endtask

    // Scoreboard: every strobe consumes the oldest expected verdict.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.result_stb === 1'b1) begin
            last_stb_cyc = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_stb (step %0d): got verdict %b, expected no strobe", step, bus.valid_Epass);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("verdict", {30'd0, bus.valid_Epass}, {30'd0, e.v});
                check("tag_id", bus.tag_id, e.tag);
            end
        end
    end

    function automatic logic [7:0] chk_of(input logic [31:0] id, input logic [7:0] bal);
        return id[31:24] ^ id[23:16] ^ id[15:8] ^ id[7:0] ^ bal;
    endfunction

    task automatic expect_pub(input logic [1:0] v, input logic [31:0] tag);
        exp_t e;
        e.v = v;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
        if (bad_stop) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] id, input logic [7:0] bal, input logic [7:0] chk,
                              input logic [7:0] etx, input int bad_idx, input bit clear_at_pub);
        logic [7:0] fb [8];
        fb[0] = 8'h02; fb[1] = id[31:24]; fb[2] = id[23:16]; fb[3] = id[15:8];
        fb[4] = id[7:0]; fb[5] = bal; fb[6] = chk; fb[7] = etx;
        for (int i = 0; i < 7; i++) send_byte(fb[i], i == bad_idx);
        t_last = cyc;
        if (clear_at_pub) begin
            fork
                send_byte(fb[7], 1'b0);
                begin
                    while (cyc < t_last + lat - 1) @(negedge clk);
                    bus.clear = 1'b1;
                    @(negedge clk);
                    bus.clear = 1'b0;
                end
            join
        end else begin
            send_byte(fb[7], bad_idx == 7);
        end
    endtask

    task automatic good_frame(input logic [31:0] id, input logic [7:0] bal, input bit clear_at_pub);
        send_frame(id, bal, chk_of(id, bal), 8'h03, -1, clear_at_pub);
    endtask

    task automatic settle_and_check_drained();
        repeat (8) @(negedge clk);
        check("pending", sb_q.size(), 32'd0);
    endtask

    task automatic check_hold_from_last_stb(input logic [1:0] v);
        while (cyc < last_stb_cyc + HOLD - 1) @(negedge clk);
        check("hold_still", {30'd0, bus.valid_Epass}, {30'd0, v});
        @(negedge clk);
        check("hold_expire", {30'd0, bus.valid_Epass}, 32'd0);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got no completion, expected finish within 95000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h12345678, 8'h05, 1'b0, 8'h03, -1, 2'b10, 32'h12345678};
        vecs[1] = '{32'h12345678, 8'h32, 1'b1, 8'h03, -1, 2'b11, 32'h12345678};
        vecs[2] = '{32'h12345678, 8'h32, 1'b0, 8'h04, -1, 2'b11, 32'h12345678};
        vecs[3] = '{32'h12345678, 8'h32, 1'b0, 8'h03,  2, 2'b11, 32'h12345678};
        vecs[4] = '{32'hA1B2C3D4, 8'h14, 1'b0, 8'h03, -1, 2'b01, 32'hA1B2C3D4};
        vecs[5] = '{32'hA1B2C3D4, 8'h13, 1'b0, 8'h03, -1, 2'b10, 32'hA1B2C3D4};
        vecs[6] = '{32'h00000001, 8'hFF, 1'b0, 8'h03, -1, 2'b01, 32'h00000001};
        vecs[7] = '{32'hDEADBEEF, 8'h50, 1'b1, 8'h03, -1, 2'b11, 32'h00000001};

        bus.rx = 1'b1;
        bus.clear = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_valid", {30'd0, bus.valid_Epass}, 32'd0);
        check("reset_tag", bus.tag_id, 32'd0);
        check("reset_stb", {31'd0, bus.result_stb}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Paid frame, hold expires exactly HOLD cycles after publication.
        step = 1;
        expect_pub(2'b01, 32'h12345678);
        good_frame(32'h12345678, 8'h32, 1'b0);
        settle_and_check_drained();
        lat = last_stb_cyc - t_last;
        check_hold_from_last_stb(2'b01);

        // Low balance, acknowledged by clear ten cycles after publication.
        step = 2;
        expect_pub(2'b10, 32'h12345678);
        good_frame(32'h12345678, 8'h05, 1'b0);
        while (cyc < last_stb_cyc + 10) @(negedge clk);
        check("pre_clear", {30'd0, bus.valid_Epass}, 32'd2);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("after_clear", {30'd0, bus.valid_Epass}, 32'd0);
        check("pending", sb_q.size(), 32'd0);

        // Table of frames: errors, balance boundaries, unsigned compare.
        for (int k = 0; k < 8; k++) begin
            step = 10 + k;
            expect_pub(vecs[k].exp_v, vecs[k].exp_tag);
            send_frame(vecs[k].id, vecs[k].bal,
                       vecs[k].chk_bad ? 8'h00 : chk_of(vecs[k].id, vecs[k].bal),
                       vecs[k].etx, vecs[k].bad_idx, 1'b0);
            settle_and_check_drained();
        end

        // Inter-byte timeout, then garbage in HUNT, then a clean frame.
        step = 20;
        expect_pub(2'b11, 32'h00000001);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        repeat (21 * CPB) @(negedge clk);
        check("pending", sb_q.size(), 32'd0);
        step = 21;
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b0);
        expect_pub(2'b01, 32'h12345678);
        good_frame(32'h12345678, 8'h32, 1'b0);
        settle_and_check_drained();

        // STX in mid-frame restarts; tag comes from the restarted frame.
        step = 22;
        expect_pub(2'b01, 32'hA1B2C3D4);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        good_frame(32'hA1B2C3D4, 8'h14, 1'b0);
        settle_and_check_drained();

        // A 4-cycle low pulse between bytes must not become a byte.
        step = 23;
        expect_pub(2'b01, 32'h12345678);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(chk_of(32'h12345678, 8'h32), 1'b0);
        send_byte(8'h03, 1'b0);
        settle_and_check_drained();

        // Clear in the publication cycle: new verdict wins and the hold restarts.
        step = 24;
        expect_pub(2'b01, 32'hA1B2C3D4);
        good_frame(32'hA1B2C3D4, 8'h14, 1'b1);
        settle_and_check_drained();
        check_hold_from_last_stb(2'b01);

        // Reset mid-frame discards the partial frame and clears outputs.
        step = 25;
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_valid", {30'd0, bus.valid_Epass}, 32'd0);
        check("midreset_tag", bus.tag_id, 32'd0);
        check("midreset_stb", {31'd0, bus.result_stb}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        expect_pub(2'b01, 32'h12345678);
        good_frame(32'h12345678, 8'h32, 1'b0);
        settle_and_check_drained();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
